// File: rtl/pmem_pkg.sv
// Shared defaults and the per-port FSM state type for the dual-port program/data memory.
package pmem_pkg;

    localparam int              DEF_ADDR_WIDTH = 32;
    localparam int              DEF_DATA_WIDTH = 32;
    localparam int              DEF_MEM_SIZE   = 4096;
    localparam logic [31:0]     DEF_MEM_BASE   = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } port_state_t;

    // Width needed to index 'depth' entries; never returns zero.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pmem_port_ctl.sv
// Handshake and read-latency controller for one memory port: IDLE -> WAIT -> RESP -> IDLE.
// The response payload is captured at acceptance and held unchanged until it is consumed.
module pmem_port_ctl
    import pmem_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  rsp_ready,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_err,
    output logic                  req_ready,
    output logic                  accept,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err,
    output port_state_t           state
);

    // WAIT lasts RD_LAT-1 cycles, so the counter starts at RD_LAT-2.
    localparam int CNT_LOAD = (RD_LAT >= 2) ? (RD_LAT - 2) : 0;
    localparam int CNT_W    = (RD_LAT > 2) ? $clog2(RD_LAT - 1) : 1;

    port_state_t            next_state;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_next;
    logic [DATA_WIDTH-1:0]  data_q;
    logic                   err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
            if (accept) begin
                data_q <= load_data;
                err_q  <= load_err;
            end
        end
    end

    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        req_ready  = (state == IDLE) && !rst;
        accept     = req_valid && req_ready;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (RD_LAT <= 1) begin
                        next_state = RESP;
                    end else begin
                        next_state = WAIT;
                        cnt_next   = CNT_W'(CNT_LOAD);
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    next_state = RESP;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Reset forces the visible response to zero even before the first reset edge.
    assign rsp_valid = (state == RESP) && !rst;
    assign rsp_data  = rst ? '0 : data_q;
    assign rsp_err   = rst ? 1'b0 : err_q;

endmodule

// File: rtl/pmem_dual.sv
// Dual-port memory: instruction fetch port (read-only) and data port (read/byte-write).
// Optional build macro PMEM_MISALIGN_ERR_EN turns misaligned requests into error responses.
//
// Handshake: a request is taken on the rising edge where req_valid && req_ready (ready only
// while that port is idle); a response is consumed on the edge where rsp_valid && rsp_ready,
// and rsp_valid/rsp_data/rsp_err hold steady until then.
module pmem_dual
    import pmem_pkg::*;
#(
    parameter int                     ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int                     DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int                     MEM_SIZE   = DEF_MEM_SIZE,
    parameter logic [ADDR_WIDTH-1:0]  MEM_BASE   = ADDR_WIDTH'(DEF_MEM_BASE),
    parameter int                     RD_LAT     = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      if_req_valid,
    output logic                      if_req_ready,
    input  logic [ADDR_WIDTH-1:0]     if_addr,
    output logic                      if_rsp_valid,
    input  logic                      if_rsp_ready,
    output logic [DATA_WIDTH-1:0]     if_rsp_data,
    output logic                      if_rsp_err,
    input  logic                      d_req_valid,
    output logic                      d_req_ready,
    input  logic [ADDR_WIDTH-1:0]     d_addr,
    input  logic                      d_we,
    input  logic [DATA_WIDTH/8-1:0]   d_wstrb,
    input  logic [DATA_WIDTH-1:0]     d_wdata,
    output logic                      d_rsp_valid,
    input  logic                      d_rsp_ready,
    output logic [DATA_WIDTH-1:0]     d_rsp_data,
    output logic                      d_rsp_err,
    output port_state_t               if_state,
    output port_state_t               d_state
);

    localparam int BYTES      = DATA_WIDTH / 8;
    localparam int BYTE_SHIFT = $clog2(BYTES);
    localparam int IDX_W      = idx_width(MEM_SIZE);
`ifdef PMEM_MISALIGN_ERR_EN
    localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'(BYTES - 1);
`endif

    logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

    function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off      = a - MEM_BASE;
        addr_err = (a < MEM_BASE) || ((off >> BYTE_SHIFT) >= ADDR_WIDTH'(MEM_SIZE));
`ifdef PMEM_MISALIGN_ERR_EN
        if ((a & LOW_MASK) != '0) begin
            addr_err = 1'b1;
        end
`endif
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
        return IDX_W'((a - MEM_BASE) >> BYTE_SHIFT);
    endfunction

    logic                  if_err;
    logic                  d_err;
    logic [IDX_W-1:0]      if_idx;
    logic [IDX_W-1:0]      d_idx;
    logic [DATA_WIDTH-1:0] if_load;
    logic [DATA_WIDTH-1:0] d_load;
    logic                  if_accept;
    logic                  d_accept;

    assign if_err = addr_err(if_addr);
    assign d_err  = addr_err(d_addr);
    assign if_idx = addr_idx(if_addr);
    assign d_idx  = addr_idx(d_addr);

    // Reads sample the array before the same edge's write lands, so a colliding fetch sees old data.
    assign if_load = if_err ? '0 : mem[if_idx];
    assign d_load  = (d_err || d_we) ? '0 : mem[d_idx];

    always_ff @(posedge clk) begin
        if (d_accept && d_we && !d_err) begin
            for (int b = 0; b < BYTES; b++) begin
                if (d_wstrb[b]) begin
                    mem[d_idx][8*b +: 8] <= d_wdata[8*b +: 8];
                end
            end
        end
    end

    pmem_port_ctl #(
        .DATA_WIDTH (DATA_WIDTH),
        .RD_LAT     (RD_LAT)
    ) u_if_ctl (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (if_req_valid),
        .rsp_ready  (if_rsp_ready),
        .load_data  (if_load),
        .load_err   (if_err),
        .req_ready  (if_req_ready),
        .accept     (if_accept),
        .rsp_valid  (if_rsp_valid),
        .rsp_data   (if_rsp_data),
        .rsp_err    (if_rsp_err),
        .state      (if_state)
    );

    pmem_port_ctl #(
        .DATA_WIDTH (DATA_WIDTH),
        .RD_LAT     (RD_LAT)
    ) u_d_ctl (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (d_req_valid),
        .rsp_ready  (d_rsp_ready),
        .load_data  (d_load),
        .load_err   (d_err),
        .req_ready  (d_req_ready),
        .accept     (d_accept),
        .rsp_valid  (d_rsp_valid),
        .rsp_data   (d_rsp_data),
        .rsp_err    (d_rsp_err),
        .state      (d_state)
    );

endmodule

// File: tb/tb_pmem_dual.sv
// Bench for pmem_dual: directed scenarios plus randomized dual-port traffic against a word-level model.
module tb_pmem_dual;
    import pmem_pkg::*;

    localparam int          MS     = 4096;
    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam int          WIN    = 16;
    localparam int          L3_LAT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        if_req_valid, if_req_ready, if_rsp_valid, if_rsp_ready, if_rsp_err;
    logic [31:0] if_addr, if_rsp_data;
    logic        d_req_valid, d_req_ready, d_we, d_rsp_valid, d_rsp_ready, d_rsp_err;
    logic [3:0]  d_wstrb;
    logic [31:0] d_addr, d_wdata, d_rsp_data;
    port_state_t if_state, d_state;

    logic        l3_if_req_valid, l3_if_req_ready, l3_if_rsp_valid, l3_if_rsp_ready, l3_if_rsp_err;
    logic [31:0] l3_if_addr, l3_if_rsp_data;
    logic        l3_d_req_valid, l3_d_req_ready, l3_d_we, l3_d_rsp_valid, l3_d_rsp_ready, l3_d_rsp_err;
    logic [3:0]  l3_d_wstrb;
    logic [31:0] l3_d_addr, l3_d_wdata, l3_d_rsp_data;
    port_state_t l3_if_state, l3_d_state;

    pmem_dual #(.RD_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_ready(if_rsp_ready),
        .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr), .d_we(d_we),
        .d_wstrb(d_wstrb), .d_wdata(d_wdata),
        .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready),
        .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
        .if_state(if_state), .d_state(d_state)
    );

    pmem_dual #(.RD_LAT(L3_LAT)) dut_l3 (
        .clk(clk), .rst(rst),
        .if_req_valid(l3_if_req_valid), .if_req_ready(l3_if_req_ready), .if_addr(l3_if_addr),
        .if_rsp_valid(l3_if_rsp_valid), .if_rsp_ready(l3_if_rsp_ready),
        .if_rsp_data(l3_if_rsp_data), .if_rsp_err(l3_if_rsp_err),
        .d_req_valid(l3_d_req_valid), .d_req_ready(l3_d_req_ready), .d_addr(l3_d_addr), .d_we(l3_d_we),
        .d_wstrb(l3_d_wstrb), .d_wdata(l3_d_wdata),
        .d_rsp_valid(l3_d_rsp_valid), .d_rsp_ready(l3_d_rsp_ready),
        .d_rsp_data(l3_d_rsp_data), .d_rsp_err(l3_d_rsp_err),
        .if_state(l3_if_state), .d_state(l3_d_state)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: plain word array keyed by word number; {err, data} responses.
    logic [31:0] model_mem [int];

    function automatic bit model_oor(input logic [31:0] a);
        longint unsigned ua;
        ua = a;
        if (ua < BASE) return 1'b1;
        if ((ua - BASE) / 4 >= MS) return 1'b1;
`ifdef PMEM_MISALIGN_ERR_EN
        if (ua % 4 != 0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic int model_word(input logic [31:0] a);
        longint unsigned ua;
        ua = a;
        return int'((ua - BASE) / 4);
    endfunction

    function automatic logic [32:0] model_rsp(input logic [31:0] a, input bit we);
        if (model_oor(a)) return {1'b1, 32'h0};
        if (we) return {1'b0, 32'h0};
        return {1'b0, model_mem[model_word(a)]};
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [3:0] strb, input logic [31:0] wd);
        logic [31:0] w;
        if (!model_oor(a)) begin
            w = model_mem.exists(model_word(a)) ? model_mem[model_word(a)] : 32'h0;
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) w[8*b +: 8] = wd[8*b +: 8];
            end
            model_mem[model_word(a)] = w;
        end
    endtask

    // Issue up to one request per port in the same cycle, then drain both responses,
    // holding each response for 'hold' cycles with rsp_ready low.
    task automatic do_pair(input bit iv, input logic [31:0] ia,
                           input bit dv, input logic [31:0] da, input bit dwe,
                           input logic [3:0] ds, input logic [31:0] dd,
                           input int ihold, input int dhold,
                           output logic [32:0] i_got, output logic [32:0] d_got);
        logic [32:0] i_exp, d_exp;
        bit ip, dp;
        int cyc, ih, dh;
        i_got = '0;
        d_got = '0;
        ih = ihold;
        dh = dhold;
        @(negedge clk);
        if_req_valid = iv; if_addr = ia;
        d_req_valid = dv; d_addr = da; d_we = dwe; d_wstrb = ds; d_wdata = dd;
        check("if_req_ready_idle", if_req_ready, 1);
        check("d_req_ready_idle", d_req_ready, 1);
        i_exp = model_rsp(ia, 1'b0);
        d_exp = model_rsp(da, dwe);
        if (dv && dwe) model_write(da, ds, dd);
        ip = iv;
        dp = dv;
        cyc = 0;
        while ((ip || dp) && cyc < 64) begin
            @(negedge clk);
            cyc++;
            if_rsp_ready = 1'b0;
            d_rsp_ready = 1'b0;
            if (cyc == 1) begin
                if_req_valid = 1'b0;
                d_req_valid = 1'b0;
                check("if_req_ready_busy", if_req_ready, !iv);
                check("d_req_ready_busy", d_req_ready, !dv);
            end
            if (ip) begin
                check("if_rsp_valid", if_rsp_valid, 1);
                check("if_rsp", {if_rsp_err, if_rsp_data}, i_exp);
                if (ih == 0) begin
                    if_rsp_ready = 1'b1;
                    ip = 1'b0;
                    i_got = {if_rsp_err, if_rsp_data};
                end else ih--;
            end
            if (dp) begin
                check("d_rsp_valid", d_rsp_valid, 1);
                check("d_rsp", {d_rsp_err, d_rsp_data}, d_exp);
                if (dh == 0) begin
                    d_rsp_ready = 1'b1;
                    dp = 1'b0;
                    d_got = {d_rsp_err, d_rsp_data};
                end else dh--;
            end
        end
        if (ip || dp) check("rsp_timeout", 1, 0);
        @(negedge clk);
        if_rsp_ready = 1'b0;
        d_rsp_ready = 1'b0;
        check("if_rsp_valid_done", if_rsp_valid, 0);
        check("d_rsp_valid_done", d_rsp_valid, 0);
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 19);
        if (r == 0) return BASE - 32'd4;
        if (r == 1) return BASE + 32'(4 * MS) + 32'(4 * $urandom_range(0, 100));
        return BASE + 32'(4 * $urandom_range(0, WIN - 1))
               + (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [32:0] ig, dg;
        rst = 1'b1;
        if_req_valid = 0; if_addr = '0; if_rsp_ready = 0;
        d_req_valid = 0; d_addr = '0; d_we = 0; d_wstrb = '0; d_wdata = '0; d_rsp_ready = 0;
        l3_if_req_valid = 0; l3_if_addr = '0; l3_if_rsp_ready = 0;
        l3_d_req_valid = 0; l3_d_addr = '0; l3_d_we = 0; l3_d_wstrb = '0; l3_d_wdata = '0;
        l3_d_rsp_ready = 0;

        repeat (3) @(negedge clk);
        check("rst_if_req_ready", if_req_ready, 0);
        check("rst_d_req_ready", d_req_ready, 0);
        check("rst_if_rsp", {if_rsp_valid, if_rsp_err, if_rsp_data}, 0);
        check("rst_d_rsp", {d_rsp_valid, d_rsp_err, d_rsp_data}, 0);
        check("rst_if_state", if_state, IDLE);
        check("rst_d_state", d_state, IDLE);
        rst = 1'b0;
        #1;
        check("post_rst_if_ready", if_req_ready, 1);
        check("post_rst_d_ready", d_req_ready, 1);

        for (int w = 0; w < WIN; w++) begin
            logic [31:0] v;
            v = (w == 0) ? 32'h0000_0013 : (w == 1) ? 32'h1122_3344 :
                (w == 2) ? 32'h5555_5555 : $urandom;
            do_pair(0, BASE, 1, BASE + 32'(4 * w), 1, 4'hF, v, 0, 0, ig, dg);
        end

        do_pair(1, BASE, 0, BASE, 0, 4'h0, 32'h0, 0, 0, ig, dg);
        check("fetch_word0", ig, {1'b0, 32'h0000_0013});

        do_pair(0, BASE, 1, BASE + 4, 1, 4'b0101, 32'hDEAD_BEEF, 0, 0, ig, dg);
        check("strb_write_rsp", dg, {1'b0, 32'h0});
        do_pair(0, BASE, 1, BASE + 4, 0, 4'h0, 32'h0, 0, 2, ig, dg);
        check("strb_merge", dg, {1'b0, 32'h11AD_33EF});

        do_pair(1, BASE + 8, 1, BASE + 8, 1, 4'hF, 32'hAAAA_AAAA, 1, 0, ig, dg);
        check("collide_old", ig, {1'b0, 32'h5555_5555});
        do_pair(1, BASE + 8, 0, BASE, 0, 4'h0, 32'h0, 0, 0, ig, dg);
        check("collide_new", ig, {1'b0, 32'hAAAA_AAAA});

        do_pair(1, BASE + 32'(4 * MS), 1, 32'h7FFF_FFFC, 0, 4'h0, 32'h0, 0, 0, ig, dg);
        check("oor_high", ig, {1'b1, 32'h0});
        check("oor_low", dg, {1'b1, 32'h0});
        do_pair(0, BASE, 1, 32'h8000_4000, 1, 4'hF, 32'hFFFF_FFFF, 0, 0, ig, dg);
        check("oor_write_rsp", dg, {1'b1, 32'h0});
        do_pair(1, BASE, 0, BASE, 0, 4'h0, 32'h0, 0, 0, ig, dg);
        check("oor_write_no_effect", ig, {1'b0, 32'h0000_0013});

        do_pair(0, BASE, 1, BASE + 2, 0, 4'h0, 32'h0, 0, 0, ig, dg);
`ifdef PMEM_MISALIGN_ERR_EN
        check("misalign", dg, {1'b1, 32'h0});
`else
        check("misalign", dg, {1'b0, 32'h0000_0013});
`endif

        // Reset during a held write response: response dropped, write kept.
        @(negedge clk);
        d_req_valid = 1; d_addr = BASE + 12; d_we = 1; d_wstrb = 4'hF; d_wdata = 32'h0BAD_CAFE;
        d_rsp_ready = 0;
        model_write(BASE + 12, 4'hF, 32'h0BAD_CAFE);
        @(negedge clk);
        d_req_valid = 0;
        check("mid_rst_valid_before", d_rsp_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_rsp", {d_rsp_valid, d_rsp_err, d_rsp_data}, 0);
        check("mid_rst_ready", d_req_ready, 0);
        rst = 1'b0;
        #1;
        check("mid_rst_ready_after", d_req_ready, 1);
        check("mid_rst_state", d_state, IDLE);
        do_pair(1, BASE + 12, 0, BASE, 0, 4'h0, 32'h0, 0, 0, ig, dg);
        check("mid_rst_write_kept", ig, {1'b0, 32'h0BAD_CAFE});

        for (int n = 0; n < 300; n++) begin
            bit we;
            we = $urandom_range(0, 1);
            do_pair($urandom_range(0, 3) != 0, rand_addr(),
                    $urandom_range(0, 3) != 0, rand_addr(), we,
                    4'($urandom_range(0, 15)), $urandom,
                    $urandom_range(0, 3), $urandom_range(0, 3), ig, dg);
        end

        // Three-cycle latency instance: write a word, then read it with the response held.
        @(negedge clk);
        l3_d_req_valid = 1; l3_d_addr = BASE + 20; l3_d_we = 1; l3_d_wstrb = 4'hF;
        l3_d_wdata = 32'hCAFE_F00D; l3_d_rsp_ready = 1;
        @(negedge clk);
        l3_d_req_valid = 0;
        repeat (5) @(negedge clk);
        check("l3_write_done", l3_d_req_ready, 1);
        l3_d_rsp_ready = 0; l3_d_we = 0; l3_d_req_valid = 1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) l3_d_req_valid = 0;
            check("l3_rsp_valid", l3_d_rsp_valid, c >= L3_LAT);
            check("l3_d_req_ready", l3_d_req_ready, 0);
            check("l3_if_req_ready", l3_if_req_ready, 1);
            if (c >= L3_LAT) check("l3_rsp", {l3_d_rsp_err, l3_d_rsp_data}, {1'b0, 32'hCAFE_F00D});
            if (c == 8) l3_d_rsp_ready = 1;
        end
        @(negedge clk);
        l3_d_rsp_ready = 0;
        check("l3_rsp_consumed", l3_d_rsp_valid, 0);
        check("l3_ready_again", l3_d_req_ready, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pmem_dual.md
PMEM_DUAL -- requirements
Module: pmem_dual

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, 32, byte address width.
REQ-002 SHALL have parameter DATA_WIDTH, 32, word width; a multiple of 8.
REQ-003 SHALL have parameter MEM_SIZE, 4096, depth in words.
REQ-004 SHALL have parameter MEM_BASE, 32'h8000_0000, byte address of word 0.
REQ-005 SHALL have parameter RD_LAT, 1, cycles from request accept to response valid; minimum 1.
REQ-006 SHALL have clk  in  1  sole clock, all logic on rising edge.
REQ-007 SHALL have rst  in  1  synchronous, active-high reset.
REQ-008 SHALL have if_req_valid / if_req_ready  in/out  1  instruction-port request handshake.
REQ-009 SHALL have if_addr  in  ADDR_WIDTH  instruction fetch byte address.
REQ-010 SHALL have if_rsp_valid / if_rsp_ready  out/in  1  instruction-port response handshake.
REQ-011 SHALL have if_rsp_data  out  DATA_WIDTH; if_rsp_err  out  1.
REQ-012 SHALL have d_req_valid / d_req_ready  in/out  1; d_addr  in  ADDR_WIDTH; d_we  in  1.
REQ-013 SHALL have d_wstrb  in  DATA_WIDTH/8  byte enables; d_wdata  in  DATA_WIDTH.
REQ-014 SHALL have d_rsp_valid / d_rsp_ready  out/in  1; d_rsp_data  out  DATA_WIDTH; d_rsp_err  out  1.

Function
REQ-015 SHALL index as idx = (addr - MEM_BASE) >> log2(DATA_WIDTH/8); low address bits are ignored.
REQ-016 SHALL flag a request out-of-range if addr < MEM_BASE or idx >= MEM_SIZE.
REQ-017 Each port SHALL run an independent FSM: IDLE -> WAIT (on accept) -> RESP (after RD_LAT cycles) -> IDLE (on rsp_valid && rsp_ready).
REQ-018 When RD_LAT = 1, WAIT SHALL last zero cycles, so rsp_valid rises on the cycle after accept.
REQ-019 req_ready SHALL be 1 only in IDLE, giving one outstanding request per port.
REQ-020 A request SHALL be accepted on the cycle where req_valid && req_ready.
REQ-021 Address, we, wstrb and wdata SHALL be captured at acceptance.
REQ-022 A read SHALL sample memory at acceptance.
REQ-023 rsp_valid, rsp_data and rsp_err SHALL stay stable in RESP until rsp_ready is asserted.
REQ-024 A data write SHALL update only the bytes whose d_wstrb bit is 1, at the acceptance edge.
REQ-025 A data write SHALL return a response with rsp_data = 0.
REQ-026 If the instruction port and the data port hit the same word in the same cycle, the instruction port SHALL read the pre-write value.
REQ-027 A data write followed by a later read SHALL return the new value.
REQ-028 An out-of-range request SHALL still complete the handshake, with rsp_err = 1 and rsp_data = 0.
REQ-029 An out-of-range write SHALL leave memory unmodified.
REQ-030 A response held in RESP with rsp_ready = 0 SHALL block further acceptance on that port only.

Reset
REQ-031 While rst = 1, both FSMs SHALL go to IDLE, with rsp_valid = 0, rsp_err = 0, rsp_data = 0 and req_ready = 0.
REQ-032 After reset, req_ready SHALL be 1 on the first cycle with rst = 0.
REQ-033 Reset asserted mid-transaction SHALL drop any in-flight response; a write already accepted SHALL remain in memory.
REQ-034 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-035 With PMEM_MISALIGN_ERR_EN defined, a request with nonzero low address bits SHALL respond rsp_err = 1, rsp_data = 0, with no write performed.
REQ-036 Without PMEM_MISALIGN_ERR_EN, low address bits SHALL be ignored silently (REQ-015).

Structure
REQ-037 Package pmem_pkg SHALL hold the default ADDR_WIDTH, DATA_WIDTH, MEM_SIZE and MEM_BASE, plus the port FSM state enum {IDLE, WAIT, RESP}.
REQ-038 The per-port handshake/latency FSM SHALL be a sub-module pmem_port_ctl, instantiated twice; the memory array stays in pmem_dual.

Verification
REQ-039 Reset, then fetch 0x8000_0000 with RD_LAT = 1 and preloaded word 0x0000_0013 -> if_rsp_valid the next cycle, data 0x0000_0013, err 0.
REQ-040 Write 0xDEAD_BEEF to 0x8000_0004 with wstrb 4'b0101, old word 0x1122_3344 -> a read returns 0x11AD_33EF.
REQ-041 Same cycle: data write 0xAAAA_AAAA and fetch, both to 0x8000_0008 (old 0x5555_5555) -> fetch returns 0x5555_5555; a later fetch returns 0xAAAA_AAAA.
REQ-042 RD_LAT = 3, read with d_rsp_ready held 0 for 5 cycles -> valid rises 3 cycles after accept, data stable, d_req_ready 0 until consumed.
REQ-043 Read 0x7FFF_FFFC and 0x8000_0000 + 4*MEM_SIZE -> err 1, data 0; a write to 0x8000_4000 leaves memory unchanged.
REQ-044 With PMEM_MISALIGN_ERR_EN, read 0x8000_0002 -> err 1; without it -> word 0 returned, err 0.
